mycpu_pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core (IF/ID/EX/MEM/WB). Owns per-stage valid bits and

---
 rtl/mycpu_pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_mycpu_pipe_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mycpu_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stage valids and handshakes, RAW hazard
// detection, A/B operand forwarding select, multi-cycle EX hold and ID-resolved PC redirect.
module mycpu_pipe_ctrl #(
   parameter int MULTI_CYCLES = 8,
   parameter bit FWD_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       if_valid_in,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_wen,
   input  logic [4:0] id_dst,
   input  logic       id_is_load,
   input  logic       id_is_multi,
   input  logic       id_br_taken,
   output logic       if_allowin,
   output logic       id_valid,
   output logic       ex_valid,
   output logic       mem_valid,
   output logic       wb_valid,
   output logic       stall_id,
   output logic [1:0] fwd_a_sel,
   output logic [1:0] fwd_b_sel,
   output logic       pc_redirect,
   output logic       ex_busy
);

   localparam int CW = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_CYCLES - 1);

   logic          id_valid_reg, ex_valid_reg, mem_valid_reg, wb_valid_reg;
   logic          ex_wen_reg, mem_wen_reg, wb_wen_reg;
   logic [4:0]    ex_dst_reg, mem_dst_reg, wb_dst_reg;
   logic          ex_is_load_reg;
   logic [CW-1:0] cnt_reg;

   logic allowin_wb, allowin_mem, allowin_ex, allowin_id;
   logic ready_go_ex, ready_go_id, hazard;

   logic [1:0][4:0] src;
   logic [1:0]      src_used, hit_ex, hit_mem, hit_wb;
   logic [1:0][1:0] sel;

   assign src      = {id_rt, id_rs};
   assign src_used = {id_use_rt, id_use_rs};

   // Per-operand match against each downstream stage; r0 never produces a hit.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         logic live;
         assign live        = src_used[gi] & (src[gi] != 5'd0);
         assign hit_ex[gi]  = live & ex_valid_reg  & ex_wen_reg  & (ex_dst_reg  == src[gi]);
         assign hit_mem[gi] = live & mem_valid_reg & mem_wen_reg & (mem_dst_reg == src[gi]);
         assign hit_wb[gi]  = live & wb_valid_reg  & wb_wen_reg  & (wb_dst_reg  == src[gi]);
         assign sel[gi]     = (!FWD_EN || hazard) ? 2'b00 :
                              hit_ex[gi]          ? 2'b01 :
                              hit_mem[gi]         ? 2'b10 :
                              hit_wb[gi]          ? 2'b11 : 2'b00;
      end
   endgenerate

   // With forwarding only a load still in EX is unresolvable; without it any pending write is.
   assign hazard = FWD_EN ? (ex_is_load_reg & (|hit_ex))
                          : (|(hit_ex | hit_mem | hit_wb));

   assign ready_go_id = ~hazard;
   assign ready_go_ex = (cnt_reg == '0);
   assign allowin_wb  = 1'b1;
   assign allowin_mem = ~mem_valid_reg | allowin_wb;
   assign allowin_ex  = ~ex_valid_reg | (ready_go_ex & allowin_mem);
   assign allowin_id  = ~id_valid_reg | (ready_go_id & allowin_ex);

   assign if_allowin  = allowin_id;
   assign id_valid    = id_valid_reg;
   assign ex_valid    = ex_valid_reg;
   assign mem_valid   = mem_valid_reg;
   assign wb_valid    = wb_valid_reg;
   assign stall_id    = id_valid_reg & ~ready_go_id;
   assign fwd_a_sel   = sel[0];
   assign fwd_b_sel   = sel[1];
   assign pc_redirect = id_valid_reg & id_br_taken & ready_go_id & allowin_ex;
   assign ex_busy     = ex_valid_reg & (cnt_reg != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_reg   <= 1'b0;
         ex_valid_reg   <= 1'b0;
         mem_valid_reg  <= 1'b0;
         wb_valid_reg   <= 1'b0;
         ex_wen_reg     <= 1'b0;
         mem_wen_reg    <= 1'b0;
         wb_wen_reg     <= 1'b0;
         ex_dst_reg     <= 5'd0;
         mem_dst_reg    <= 5'd0;
         wb_dst_reg     <= 5'd0;
         ex_is_load_reg <= 1'b0;
         cnt_reg        <= '0;
      end else begin
         if (allowin_id)
            id_valid_reg <= if_valid_in;
         if (allowin_ex) begin
            ex_valid_reg   <= id_valid_reg & ready_go_id;
            ex_wen_reg     <= id_wen;
            ex_dst_reg     <= id_dst;
            ex_is_load_reg <= id_is_load;
         end
         if (allowin_mem) begin
            mem_valid_reg <= ex_valid_reg & ready_go_ex;
            mem_wen_reg   <= ex_wen_reg;
            mem_dst_reg   <= ex_dst_reg;
         end
         wb_valid_reg <= mem_valid_reg;
         wb_wen_reg   <= mem_wen_reg;
         wb_dst_reg   <= mem_dst_reg;
         // Counter arms as a multi-cycle op enters EX and runs down to zero.
         if (allowin_ex && id_valid_reg && ready_go_id && id_is_multi)
            cnt_reg <= CNT_LOAD;
         else if (cnt_reg != '0)
            cnt_reg <= cnt_reg - 1'b1;
      end
   end

endmodule

// File: tb/tb_mycpu_pipe_ctrl.sv
// Bench for mycpu_pipe_ctrl: occupancy-level pipeline model compared every cycle, plus
// hand-computed expectations for forwarding, stalls, multi-cycle hold, branch and reset.
module tb_mycpu_pipe_ctrl;
   localparam int M = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, if_valid_in;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       id_use_rs, id_use_rt, id_wen, id_is_load, id_is_multi, id_br_taken;

   logic       f_allow, f_idv, f_exv, f_memv, f_wbv, f_stall, f_red, f_busy;
   logic [1:0] f_fa, f_fb;
   logic       n_allow, n_idv, n_exv, n_memv, n_wbv, n_stall, n_red, n_busy;
   logic [1:0] n_fa, n_fb;
   logic       o_allow, o_idv, o_exv, o_memv, o_wbv, o_stall, o_red, o_busy;
   logic [1:0] o_fa, o_fb;
   bit         fwd_mode;

   mycpu_pipe_ctrl #(.MULTI_CYCLES(M), .FWD_EN(1'b1)) dut_f (
      .clk(clk), .rst(rst), .if_valid_in(if_valid_in), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_dst(id_dst),
      .id_is_load(id_is_load), .id_is_multi(id_is_multi), .id_br_taken(id_br_taken),
      .if_allowin(f_allow), .id_valid(f_idv), .ex_valid(f_exv), .mem_valid(f_memv),
      .wb_valid(f_wbv), .stall_id(f_stall), .fwd_a_sel(f_fa), .fwd_b_sel(f_fb),
      .pc_redirect(f_red), .ex_busy(f_busy));

   mycpu_pipe_ctrl #(.MULTI_CYCLES(M), .FWD_EN(1'b0)) dut_n (
      .clk(clk), .rst(rst), .if_valid_in(if_valid_in), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_dst(id_dst),
      .id_is_load(id_is_load), .id_is_multi(id_is_multi), .id_br_taken(id_br_taken),
      .if_allowin(n_allow), .id_valid(n_idv), .ex_valid(n_exv), .mem_valid(n_memv),
      .wb_valid(n_wbv), .stall_id(n_stall), .fwd_a_sel(n_fa), .fwd_b_sel(n_fb),
      .pc_redirect(n_red), .ex_busy(n_busy));

   always_comb begin
      o_allow = fwd_mode ? f_allow : n_allow;
      o_idv   = fwd_mode ? f_idv   : n_idv;
      o_exv   = fwd_mode ? f_exv   : n_exv;
      o_memv  = fwd_mode ? f_memv  : n_memv;
      o_wbv   = fwd_mode ? f_wbv   : n_wbv;
      o_stall = fwd_mode ? f_stall : n_stall;
      o_red   = fwd_mode ? f_red   : n_red;
      o_busy  = fwd_mode ? f_busy  : n_busy;
      o_fa    = fwd_mode ? f_fa    : n_fa;
      o_fb    = fwd_mode ? f_fb    : n_fb;
   end

   typedef struct {
      bit gap; logic [4:0] rs, rt, dst;
      bit urs, urt, wen, ld, mul, br; int tag;
   } instr_t;
   typedef struct { bit v; instr_t i; int rem; } stage_t;

   instr_t prog[$];
   int     pc;
   stage_t m_id, m_ex, m_mem, m_wb;
   int     checks = 0, failures = 0;

   bit         e_allow, e_idv, e_exv, e_memv, e_wbv, e_stall, e_red, e_busy, chk_on;
   logic [1:0] e_fa, e_fb;
   bit         s_ex_free, s_id_moves, s_id_free;

   int stall_cnt, busy_cnt, red_cnt, red_after_stall, held_cnt, watch_tag, ds_tag;
   bit prev_stall, ds_seen;
   int cap_a[32], cap_b[32];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_i(input bit gap, input logic [4:0] dst, input logic [4:0] rs,
                        input logic [4:0] rt, input bit urs, input bit urt, input bit wen,
                        input bit ld, input bit mul, input bit br);
      instr_t x;
      x.gap = gap; x.dst = dst; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
      x.wen = wen; x.ld = ld; x.mul = mul; x.br = br; x.tag = prog.size();
      prog.push_back(x);
   endtask
   task automatic addu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      add_i(0, d, s, t, 1, 1, 1, 0, 0, 0);
   endtask
   task automatic lw(input logic [4:0] d, input logic [4:0] b);
      add_i(0, d, b, 5'd0, 1, 0, 1, 1, 0, 0);
   endtask
   task automatic mult(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      add_i(0, d, s, t, 1, 1, 1, 0, 1, 0);
   endtask
   task automatic beq(input logic [4:0] s, input logic [4:0] t);
      add_i(0, 5'd0, s, t, 1, 1, 0, 0, 0, 1);
   endtask
   task automatic gap();
      add_i(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic bit mt(input stage_t s, input logic [4:0] r);
      return s.v && s.i.wen && (s.i.dst == r) && (r != 5'd0);
   endfunction
   function automatic bit uses(input stage_t s);
      return (m_id.i.urs && mt(s, m_id.i.rs)) || (m_id.i.urt && mt(s, m_id.i.rt));
   endfunction
   function automatic logic [1:0] pick(input bit u, input logic [4:0] r);
      if (!u) return 2'b00;
      if (mt(m_ex, r))  return 2'b01;
      if (mt(m_mem, r)) return 2'b10;
      if (mt(m_wb, r))  return 2'b11;
      return 2'b00;
   endfunction

   task automatic drive_inputs();
      if_valid_in = (pc < prog.size()) && !prog[pc].gap;
      id_rs = m_id.v ? m_id.i.rs : 5'd0;     id_rt = m_id.v ? m_id.i.rt : 5'd0;
      id_use_rs = m_id.v && m_id.i.urs;      id_use_rt = m_id.v && m_id.i.urt;
      id_wen = m_id.v && m_id.i.wen;         id_dst = m_id.v ? m_id.i.dst : 5'd0;
      id_is_load = m_id.v && m_id.i.ld;      id_is_multi = m_id.v && m_id.i.mul;
      id_br_taken = m_id.v && m_id.i.br;
   endtask

   task automatic model_eval();
      bit hz;
      if (fwd_mode) hz = m_id.v && m_ex.v && m_ex.i.ld && uses(m_ex);
      else          hz = m_id.v && (uses(m_ex) || uses(m_mem) || uses(m_wb));
      s_ex_free  = !m_ex.v || (m_ex.rem == 0);
      s_id_moves = m_id.v && !hz && s_ex_free;
      s_id_free  = !m_id.v || s_id_moves;
      e_allow = s_id_free;  e_idv = m_id.v;  e_exv = m_ex.v;  e_memv = m_mem.v;  e_wbv = m_wb.v;
      e_stall = hz;
      e_busy  = m_ex.v && (m_ex.rem != 0);
      e_red   = s_id_moves && m_id.i.br;
      e_fa    = (fwd_mode && !hz) ? pick(m_id.i.urs, m_id.i.rs) : 2'b00;
      e_fb    = (fwd_mode && !hz) ? pick(m_id.i.urt, m_id.i.rt) : 2'b00;
   endtask

   task automatic model_update();
      if (rst) begin
         m_id.v = 0; m_ex.v = 0; m_mem.v = 0; m_wb.v = 0; m_ex.rem = 0;
      end else begin
         m_wb    = m_mem;
         m_mem.v = m_ex.v && (m_ex.rem == 0);
         m_mem.i = m_ex.i;
         if (s_ex_free) begin
            m_ex.v = s_id_moves; m_ex.i = m_id.i; m_ex.rem = m_id.i.mul ? M - 1 : 0;
         end else begin
            m_ex.rem--;
         end
         if (s_id_free) begin
            m_id.v = if_valid_in;
            if (if_valid_in) m_id.i = prog[pc];
         end
         if (pc < prog.size() && (prog[pc].gap || s_id_free)) pc++;
      end
   endtask

   task automatic cycle();
      drive_inputs();
      model_eval();
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("if_allowin", o_allow, e_allow);
         check("id_valid",   o_idv,   e_idv);
         check("ex_valid",   o_exv,   e_exv);
         check("mem_valid",  o_memv,  e_memv);
         check("wb_valid",   o_wbv,   e_wbv);
         check("stall_id",   o_stall, e_stall);
         check("pc_redirect", o_red,  e_red);
         check("ex_busy",    o_busy,  e_busy);
         if (e_idv && !e_stall) begin
            check("fwd_a_sel", o_fa, e_fa);
            check("fwd_b_sel", o_fb, e_fb);
            if (m_id.i.tag < 32) begin
               cap_a[m_id.i.tag] = o_fa;
               cap_b[m_id.i.tag] = o_fb;
            end
         end
         stall_cnt += o_stall;
         busy_cnt  += o_busy;
         red_cnt   += o_red;
         if (o_red && prev_stall) red_after_stall++;
         prev_stall = o_stall;
         if (e_idv && m_id.i.tag == watch_tag && !o_allow) held_cnt++;
         if (e_wbv && m_wb.i.tag == ds_tag && o_wbv) ds_seen = 1;
      end
   end

   task automatic start_test(input bit fm);
      fwd_mode = fm; pc = 0;
      stall_cnt = 0; busy_cnt = 0; red_cnt = 0; red_after_stall = 0; held_cnt = 0;
      prev_stall = 0; ds_seen = 0; watch_tag = -1; ds_tag = -1;
      for (int i = 0; i < 32; i++) begin cap_a[i] = -1; cap_b[i] = -1; end
      rst = 1; chk_on = 0;
      cycle();
      check("rst_id_valid", o_idv, 0);   check("rst_ex_valid", o_exv, 0);
      check("rst_mem_valid", o_memv, 0); check("rst_wb_valid", o_wbv, 0);
      check("rst_if_allowin", o_allow, 1);
      check("rst_fwd_a", o_fa, 0);       check("rst_fwd_b", o_fb, 0);
      check("rst_ex_busy", o_busy, 0);   check("rst_redirect", o_red, 0);
      chk_on = 1;
      cycle();
      rst = 0;
   endtask

   initial begin
      rst = 1; chk_on = 0; fwd_mode = 1; pc = 0;
      m_id.v = 0; m_ex.v = 0; m_mem.v = 0; m_wb.v = 0; m_ex.rem = 0;
      drive_inputs();
      @(posedge clk); #1;

      // Forwarding distance: adjacent, one bubble, two bubbles, r0 destination.
      prog.delete();
      addu(3, 1, 2); addu(4, 3, 3); addu(7, 1, 2); gap(); addu(8, 7, 7);
      addu(9, 1, 2); gap(); gap(); addu(10, 9, 9); addu(0, 1, 2); addu(11, 0, 0);
      start_test(1);
      cycle();
      check("first_in_id", o_idv, 1);
      repeat (25) cycle();
      check("fwd_ex_a", cap_a[1], 1);  check("fwd_ex_b", cap_b[1], 1);
      check("fwd_mem_a", cap_a[4], 2);
      check("fwd_wb_a", cap_a[8], 3);  check("fwd_wb_b", cap_b[8], 3);
      check("fwd_r0_a", cap_a[10], 0); check("t1_stalls", stall_cnt, 0);

      // Load-use.
      prog.delete();
      lw(5, 1); addu(6, 5, 0);
      start_test(1);
      repeat (15) cycle();
      check("lu_stalls", stall_cnt, 1);
      check("lu_fwd_a", cap_a[1], 2); check("lu_fwd_b", cap_b[1], 0);

      // Multi-cycle op holds its successor.
      prog.delete();
      mult(12, 1, 2); addu(13, 1, 2); addu(14, 12, 13);
      start_test(1);
      watch_tag = 1;
      repeat (30) cycle();
      check("mc_busy_cycles", busy_cnt, 7);
      check("mc_held_cycles", held_cnt, 7);
      check("mc_fwd_a", cap_a[2], 2); check("mc_fwd_b", cap_b[2], 1);

      // Taken branch behind a load-use stall; delay slot survives.
      prog.delete();
      lw(5, 1); beq(5, 0); addu(15, 1, 2); addu(16, 1, 2);
      start_test(1);
      ds_tag = 2;
      repeat (20) cycle();
      check("br_pulses", red_cnt, 1);
      check("br_after_stall", red_after_stall, 1);
      check("br_stalls", stall_cnt, 1);
      check("delay_slot_wb", ds_seen, 1);

      // No forwarding: adjacent dependency waits until the producer leaves WB.
      prog.delete();
      addu(3, 1, 2); addu(4, 3, 3);
      start_test(0);
      repeat (15) cycle();
      check("nf_stalls", stall_cnt, 3);
      check("nf_fwd_a", cap_a[1], 0);

      // Reset in the middle of a multi-cycle op.
      prog.delete();
      mult(12, 1, 2); addu(13, 1, 2);
      start_test(1);
      for (int k = 0; k < 40 && busy_cnt < 3; k++) cycle();
      check("mr_reached_busy", busy_cnt >= 3, 1);
      rst = 1;
      cycle();
      rst = 0;
      check("mr_id_valid", o_idv, 0);   check("mr_ex_valid", o_exv, 0);
      check("mr_mem_valid", o_memv, 0); check("mr_wb_valid", o_wbv, 0);
      check("mr_ex_busy", o_busy, 0);
      repeat (5) cycle();

      chk_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
